c3lib_gray_codec_pipe: RTL

Parametrised, pipelined, multi-channel Gray/binary code converter with valid/ready flow control and a per-channel Gray single-step checker. It replaces combinational Gray-to-binary decoding where WIDTH is too wide to close timing in one cycle. It sits on the receive side of CDC pointer paths, for example async FIFO read/write pointer resolution and multi-lane status counters, after the synchronizer stage. A per-beat mode bit also supports binary-to-Gray encoding on the same datapath.

---
 rtl/c3lib_gray_codec_pipe.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/c3lib_gray_codec_pipe.sv
`default_nettype none
// ============================================================================
// Module      : c3lib_gray_codec_pipe
// Description : Pipelined multi-channel Gray/binary converter with valid/ready
//               flow control and a sticky per-channel Gray single-step checker.
//               Mode 0 decodes Gray to binary with the XOR prefix chain split
//               across STAGES register slices. Mode 1 encodes binary to Gray.
//               Each beat carries its own mode through the pipe.
// Ports       : clk, rst_n (async assert, active low)
//               in_valid/in_ready/in_mode/data_in   - input beat
//               out_valid/out_ready/out_mode/data_out - converted beat
//               err_clr  - synchronous clear of step_err
//               step_err - sticky per-channel Gray step violation
// Revision    : 1.0 - initial release
// ============================================================================
module c3lib_gray_codec_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 1,
    parameter int STAGES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_mode,
    output logic [NUM_CH*WIDTH-1:0] data_out,
    input  logic                    err_clr,
    output logic [NUM_CH-1:0]       step_err
);

    localparam int c_DATA_W = NUM_CH * WIDTH;
    // Prefix levels resolved per slice; STAGES * c_LVL >= WIDTH always.
    localparam int c_LVL    = (WIDTH + STAGES - 1) / STAGES;

    // ------------------------------------------------------------------------
    // Conversion helpers
    // ------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] f_bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Resolves Gray bits [hi:lo] of a partially decoded word. Every bit above
    // hi is already binary, so each bit is the binary bit above it XOR its own
    // Gray bit. The MSB is identical in both codes and is never touched.
    function automatic logic [WIDTH-1:0] f_g2b_slice(
        input logic [WIDTH-1:0] d,
        input int               lo,
        input int               hi
    );
        logic [WIDTH-1:0] r;
        r = d;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            if (i >= lo && i <= hi) begin
                r[i] = r[i + 1] ^ d[i];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Pipeline slices
    // ------------------------------------------------------------------------
    logic [c_DATA_W-1:0] r_data      [STAGES];
    logic [STAGES-1:0]   r_valid;
    logic [STAGES-1:0]   r_mode;

    logic [c_DATA_W-1:0] w_stage_out [STAGES];
    logic [STAGES-1:0]   w_vin;
    logic [STAGES-1:0]   w_min;
    logic                w_stall;

    // Global stall: the whole pipe freezes while the output beat is refused.
    assign w_stall  = r_valid[STAGES-1] && !out_ready;
    assign in_ready = !w_stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_HI     = WIDTH - 1 - k * c_LVL;
        localparam int c_LO_RAW = WIDTH - (k + 1) * c_LVL;
        localparam int c_LO     = (c_LO_RAW > 0) ? c_LO_RAW : 0;

        logic [c_DATA_W-1:0] w_din;
        logic                w_vld;
        logic                w_md;
        logic [c_DATA_W-1:0] w_conv;

        if (k == 0) begin : g_head
            assign w_din = data_in;
            assign w_vld = in_valid;
            assign w_md  = in_mode;
        end else begin : g_body
            assign w_din = r_data[k-1];
            assign w_vld = r_valid[k-1];
            assign w_md  = r_mode[k-1];
        end

        // Mode 1 needs a single XOR level, done entirely in the first slice;
        // later slices pass mode-1 beats through untouched.
        always_comb begin
            w_conv = w_din;
            for (int c = 0; c < NUM_CH; c++) begin
                if (!w_md) begin
                    w_conv[c*WIDTH +: WIDTH] =
                        f_g2b_slice(w_din[c*WIDTH +: WIDTH], c_LO, c_HI);
                end else if (k == 0) begin
                    w_conv[c*WIDTH +: WIDTH] = f_bin2gray(w_din[c*WIDTH +: WIDTH]);
                end
            end
        end

        assign w_stage_out[k] = w_conv;
        assign w_vin[k]       = w_vld;
        assign w_min[k]       = w_md;
    end

    // Bubbles advance with the pipe and are never collapsed; slice data is
    // loaded regardless of valid since it is qualified by the valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_mode  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= '0;
            end
        end else if (!w_stall) begin
            r_valid <= w_vin;
            r_mode  <= w_min;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= w_stage_out[k];
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_mode  = r_mode[STAGES-1];
    assign data_out  = r_data[STAGES-1];

    // ------------------------------------------------------------------------
    // Gray single-step checker (input side, independent of pipeline depth)
    // ------------------------------------------------------------------------
    logic                w_accept;
    logic [c_DATA_W-1:0] r_prev;
    logic                r_primed;
    logic [NUM_CH-1:0]   r_step_err;
    logic [NUM_CH-1:0]   w_viol;
    logic [WIDTH-1:0]    w_diff;

    assign w_accept = in_valid && in_ready;

    // More than one bit changed <=> diff has a set bit after clearing its
    // lowest set bit.
    always_comb begin
        w_viol = '0;
        w_diff = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_diff    = data_in[c*WIDTH +: WIDTH] ^ r_prev[c*WIDTH +: WIDTH];
            w_viol[c] = w_accept && !in_mode && r_primed &&
                        ((w_diff & (w_diff - WIDTH'(1))) != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev     <= '0;
            r_primed   <= 1'b0;
            r_step_err <= '0;
        end else begin
            // A new violation overrides a simultaneous clear.
            r_step_err <= (r_step_err & ~{NUM_CH{err_clr}}) | w_viol;
            if (w_accept) begin
                if (in_mode) begin
                    r_primed <= 1'b0;
                end else begin
                    r_primed <= 1'b1;
                    r_prev   <= data_in;
                end
            end
        end
    end

    assign step_err = r_step_err;

endmodule
`default_nettype wire
